// File: rtl/spinner2quad_pkg.sv
// Shared types, Gray table and clamp helper for the spinner-to-quadrature path.
package spinner_pkg;

  typedef logic [1:0] quad_phase_t;

  localparam logic [1:0] QUAD_GRAY [0:3] = '{
    2'b00, 2'b01, 2'b11, 2'b10
  };

  function automatic int sat_add(
    input int a,
    input int b,
    input int lim
  );
    int s;
    s = a + b;
    if (s > lim) return lim;
    if (s < -lim) return -lim;
    return s;
  endfunction

endpackage

// File: rtl/spinner2quad_step_tick_div.sv
// Free-running step-rate divider; one tick every CLKDIV cycles.
module step_tick_div #(
  parameter int CLKDIV = 22500
) (
  input  logic CLK,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLKDIV - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge CLK) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spinner2quad.sv
// Banks signed spinner deltas and replays them as rate-limited
// two-phase Gray quadrature for the steering inputs.
module spinner2quad
  import spinner_pkg::*;
#(
  parameter int CLKDIV      = 22500,
  parameter int DELTA_W     = 8,
  parameter int ACC_W       = 10,
  parameter int MAX_PENDING = 255
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    delta_valid,
  input  logic signed [DELTA_W-1:0] delta,
  input  logic                    clear,
  output logic [1:0]              steer,
  output logic signed [ACC_W-1:0] pending,
  output logic                    step_strobe
);

  logic                    tick;
  logic                    up;
  logic                    dn;
  logic                    strobe_nxt;
  quad_phase_t             phase;
  quad_phase_t             phase_nxt;
  logic signed [ACC_W-1:0] pend_nxt;
  int                      step_adj;
  int                      acc_sum;

  step_tick_div #(
    .CLKDIV(CLKDIV)
  ) u_div (
    .CLK  (CLK),
    .reset(reset),
    .clr  (clear),
    .tick (tick)
  );

  // Step direction comes from the registered count, not the incoming delta.
  always_comb begin
    step_adj  = 0;
    phase_nxt = phase;
    up        = (pending > 0);
    dn        = (pending < 0);
    if (tick && up) begin
      step_adj  = -1;
      phase_nxt = phase + 2'd1;
    end else if (tick && dn) begin
      step_adj  = 1;
      phase_nxt = phase - 2'd1;
    end
    acc_sum = sat_add(
      int'(pending) + step_adj,
      delta_valid ? int'(delta) : 0,
      MAX_PENDING
    );
    pend_nxt   = ACC_W'(acc_sum);
    strobe_nxt = tick && (up || dn);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      phase       <= '0;
      steer       <= QUAD_GRAY[0];
      pending     <= '0;
      step_strobe <= 1'b0;
    end else if (clear) begin
      pending     <= '0;
      step_strobe <= 1'b0;
    end else begin
      phase       <= phase_nxt;
      steer       <= QUAD_GRAY[phase_nxt];
      pending     <= pend_nxt;
      step_strobe <= strobe_nxt;
    end
  end

endmodule

// File: tb/tb_spinner2quad.sv
// Randomised scoreboard bench for spinner2quad with directed corner cases.
module tb_spinner2quad;

  localparam int CLKDIV = 4;
  localparam int MAXP   = 255;

  logic              clk = 1'b0;
  logic              reset;
  logic              delta_valid;
  logic signed [7:0] delta;
  logic              clear;
  logic [1:0]        steer;
  logic signed [9:0] pending;
  logic              step_strobe;

  int errors = 0;
  int checks = 0;

  int m_pend  = 0;
  int m_cyc   = 0;
  int m_phase = 0;
  bit m_strobe = 0;
  logic [1:0] exp_q [$];

  always #5 clk = ~clk;

  spinner2quad #(
    .CLKDIV     (CLKDIV),
    .DELTA_W    (8),
    .ACC_W      (10),
    .MAX_PENDING(MAXP)
  ) dut (
    .CLK        (clk),
    .reset      (reset),
    .delta_valid(delta_valid),
    .delta      (delta),
    .clear      (clear),
    .steer      (steer),
    .pending    (pending),
    .step_strobe(step_strobe)
  );

  function automatic logic [1:0] gray(input int p);
    logic [1:0] b;
    b = 2'(p);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: steps drawn every CLKDIV cycles since the last reset/clear.
  always @(posedge clk) begin
    int acc;
    bit tk;
    if (reset) begin
      m_pend = 0; m_cyc = 0; m_phase = 0; m_strobe = 0;
    end else if (clear) begin
      m_pend = 0; m_cyc = 0; m_strobe = 0;
    end else begin
      tk = (m_cyc % CLKDIV) == CLKDIV - 1;
      m_cyc++;
      acc = m_pend + (delta_valid ? int'(delta) : 0);
      m_strobe = 0;
      if (tk && m_pend > 0) begin
        acc -= 1; m_phase = (m_phase + 1) % 4; m_strobe = 1;
        exp_q.push_back(gray(m_phase));
      end else if (tk && m_pend < 0) begin
        acc += 1; m_phase = (m_phase + 3) % 4; m_strobe = 1;
        exp_q.push_back(gray(m_phase));
      end
      if (acc > MAXP) acc = MAXP;
      if (acc < -MAXP) acc = -MAXP;
      m_pend = acc;
    end
  end

  // Monitor: every strobe must match the next queued step.
  always @(negedge clk) begin
    chk("pending", int'(pending), m_pend);
    chk("strobe", int'(step_strobe), int'(m_strobe));
    chk("steer", int'(steer), int'(gray(m_phase)));
    if (step_strobe) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_step", 1, 0);
      end else begin
        chk("step_steer", int'(steer), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1; cyc(1); clear = 1'b0;
  endtask

  task automatic send(input int d);
    delta_valid = 1'b1; delta = 8'(d); cyc(1);
    delta_valid = 1'b0; delta = '0;
  endtask

  initial begin
    logic [1:0] held;
    reset = 1'b1; delta_valid = 1'b0; delta = '0; clear = 1'b0;
    cyc(1);
    for (int i = 0; i < 20; i++) begin
      chk("rst_steer", int'(steer), 0);
      chk("rst_pending", int'(pending), 0);
      chk("rst_strobe", int'(step_strobe), 0);
      cyc(1);
    end
    reset = 1'b0;

    // +3 then -2 from a realigned divider
    do_clear();
    send(3);
    chk("plus3_pending", int'(pending), 3);
    cyc(20);
    chk("plus3_steer", int'(steer), 2);
    chk("plus3_done", int'(pending), 0);
    reset = 1'b1; cyc(1); reset = 1'b0;
    send(-2);
    cyc(12);
    chk("minus2_steer", int'(steer), 3);

    // saturation both ways
    do_clear();
    send(127); send(127); send(10);
    chk("sat_pos", int'(pending), 255);
    do_clear();
    send(-128); send(-128); send(-128);
    chk("sat_neg", int'(pending), -255);

    // delta landing on the tick cycle
    do_clear();
    delta_valid = 1'b1; delta = 8'sd1; cyc(1);
    delta_valid = 1'b0; cyc(2);
    delta_valid = 1'b1; cyc(1);
    delta_valid = 1'b0; delta = '0;
    chk("simul_pending", int'(pending), 1);
    chk("simul_strobe", int'(step_strobe), 1);

    // clear mid-run holds steer and kills strobes
    do_clear();
    send(5);
    cyc(1);
    held = steer;
    do_clear();
    chk("clr_pending", int'(pending), 0);
    chk("clr_steer", int'(steer), int'(held));
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk("clr_quiet", int'(step_strobe), 0);
    end

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      delta_valid = ($urandom_range(0, 99) < 20);
      delta       = 8'($urandom);
      clear       = ($urandom_range(0, 199) == 0);
      reset       = ($urandom_range(0, 499) == 0);
      cyc(1);
    end
    delta_valid = 1'b0; clear = 1'b0; reset = 1'b0;
    cyc(CLKDIV * 2);
    do_clear();
    cyc(2);
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
